simple_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits directly downstream of the simple-system bus as an additional device next to Ram, SimCtrl and Timer, for example at base 0x40000 with a 1 kB mask.
- Software pushes bytes into a TX FIFO.
- A baud-rate engine serialises each byte as 8N1 on tx_o.
- A level interrupt reports "transmitter drained" to the core's irq_external_i.

---
 rtl/simple_uart_pkg.sv | 29 ++
 rtl/simple_uart_fifo.sv | 66 ++++++
 rtl/simple_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_simple_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// control/status bit positions and transmit FSM state encoding.
package simple_uart_pkg;

    localparam logic [9:0] TXDATA = 10'h000;
    localparam logic [9:0] STATUS = 10'h004;
    localparam logic [9:0] CLKDIV = 10'h008;
    localparam logic [9:0] CTRL   = 10'h00C;

    localparam int CTRL_TX_EN       = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_BUSY      = 2;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // A divider of zero would never advance the bit timer, so it behaves as one.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/simple_uart_fifo.sv
// Synchronous show-ahead FIFO with registered pointers and occupancy count.
// A push while full is refused even when a pop happens in the same cycle.
module simple_uart_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CntW'(Depth));
    assign w_empty = (r_count == '0);
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata_o = r_mem[r_rd_ptr];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = r_count;

endmodule

// File: rtl/simple_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register file, single-cycle bus response,
// TX FIFO and the serialising FSM with a drained-transmitter level interrupt.
module simple_uart_tx
    import simple_uart_pkg::*;
#(
    parameter int          FifoDepth    = 16,
    parameter logic [15:0] ClkDivReset  = 16'd868,
    parameter int          AddressWidth = 32,
    parameter int          DataWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int CntW = $clog2(FifoDepth) + 1;

    logic [9:0]           w_offset;
    logic                 w_wr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CntW-1:0]      w_count;
    logic [7:0]           w_fifo_rdata;
    logic [DataWidth-1:0] w_rsp_data;
    logic                 w_rsp_err;
    logic                 w_last_tick;
    logic                 w_can_start;
    logic                 w_unused;

    logic [15:0]          r_clkdiv;
    logic [1:0]           r_ctrl;
    logic                 r_rvalid;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_err;
    uart_state_e          r_state;
    logic [7:0]           r_shift;
    logic [15:0]          r_div;
    logic [15:0]          r_cnt;
    logic [2:0]           r_bit;
    logic                 r_tx;
    logic                 r_irq;

    assign w_unused = ^{addr_i[AddressWidth-1:10], addr_i[1:0], be_i[3:2], wdata_i[DataWidth-1:16]};

    assign w_offset = {addr_i[9:2], 2'b00};
    assign w_wr     = req_i & we_i;
    assign w_push   = w_wr & (w_offset == TXDATA) & be_i[0] & ~w_full;

    simple_uart_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .wdata_i (wdata_i[7:0]),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_comb begin
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        case (w_offset)
            TXDATA: w_rsp_err = we_i & w_full;
            STATUS: begin
                w_rsp_err = we_i;
                if (!we_i) begin
                    w_rsp_data[STATUS_FULL]               = w_full;
                    w_rsp_data[STATUS_EMPTY]              = w_empty;
                    w_rsp_data[STATUS_BUSY]               = (r_state != IDLE);
                    w_rsp_data[STATUS_COUNT_LSB +: 8]     = 8'(w_count);
                end
            end
            CLKDIV: if (!we_i) w_rsp_data[15:0] = r_clkdiv;
            CTRL:   if (!we_i) w_rsp_data[1:0]  = r_ctrl;
            default: w_rsp_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_clkdiv <= ClkDivReset;
            r_ctrl   <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= req_i ? w_rsp_data : '0;
            r_err    <= req_i & w_rsp_err;
            if (w_wr && (w_offset == CLKDIV)) begin
                for (int b = 0; b < 2; b++) begin
                    if (be_i[b]) begin
                        r_clkdiv[8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
            if (w_wr && (w_offset == CTRL) && be_i[0]) begin
                r_ctrl <= wdata_i[1:0];
            end
        end
    end

    // A new frame can begin from IDLE or on the final tick of STOP, so
    // consecutive bytes leave no idle gap on the line.
    assign w_last_tick = (r_cnt == (r_div - 16'd1));
    assign w_can_start = r_ctrl[CTRL_TX_EN] & ~w_empty;
    assign w_pop       = w_can_start & ((r_state == IDLE) | ((r_state == STOP) & w_last_tick));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_div   <= 16'd1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= r_ctrl[CTRL_IRQ_EN] & w_empty & (r_state == IDLE);
            if (w_pop) begin
                r_shift <= w_fifo_rdata;
                r_div   <= clamp_div(r_clkdiv);
                r_cnt   <= '0;
                r_bit   <= '0;
                r_state <= START;
                r_tx    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_tx <= 1'b1;
                    START: begin
                        if (w_last_tick) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (w_last_tick) begin
                            r_cnt   <= '0;
                            r_shift <= r_shift >> 1;
                            if (r_bit == 3'd7) begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                                r_tx  <= r_shift[1];
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    STOP: begin
                        if (w_last_tick) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign tx_o     = r_tx;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_simple_uart_tx.sv
// Bench for simple_uart_tx: a waveform-level model checked every cycle plus
// directed scenarios with hand-computed line patterns and register values.
module tb_simple_uart_tx;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        tx_o;
    logic        irq_o;

    always #5 clk_i = ~clk_i;

    simple_uart_tx #(
        .FifoDepth    (DEPTH),
        .ClkDivReset  (16'd868),
        .AddressWidth (32),
        .DataWidth    (32)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .tx_o     (tx_o),
        .irq_o    (irq_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes waiting, the line waveform still to be driven, and registers.
    logic [7:0]  m_fifo[$];
    bit          m_wave[$];
    logic [15:0] m_clkdiv;
    logic [1:0]  m_ctrl;
    bit          m_busy;
    logic        m_tx;
    logic        m_irq;
    logic        m_rvalid;
    logic        m_err;
    logic [31:0] m_rdata;
    bit          m_live = 1'b0;

    task automatic model_step();
        int          n;
        int          d;
        bit          full_pre;
        bit          empty_pre;
        bit          busy_pre;
        logic [1:0]  ctrl_pre;
        logic [15:0] div_pre;
        logic [9:0]  off;
        logic [31:0] rd;
        logic        er;
        logic [7:0]  b;
        bit          v;
        if (rst_i) begin
            m_fifo.delete();
            m_wave.delete();
            m_clkdiv = 16'd868;
            m_ctrl   = 2'b00;
            m_busy   = 1'b0;
            m_tx     = 1'b1;
            m_irq    = 1'b0;
            m_rvalid = 1'b0;
            m_err    = 1'b0;
            m_rdata  = '0;
            m_live   = 1'b1;
            return;
        end
        if (!m_live) return;
        n         = m_fifo.size();
        full_pre  = (n == DEPTH);
        empty_pre = (n == 0);
        busy_pre  = m_busy;
        ctrl_pre  = m_ctrl;
        div_pre   = m_clkdiv;

        // Line: a new 10-bit frame begins only once the previous one is fully driven.
        if (m_wave.size() == 0 && ctrl_pre[0] && !empty_pre) begin
            b = m_fifo.pop_front();
            d = (div_pre == 16'd0) ? 1 : int'(div_pre);
            for (int k = 0; k < 10; k++) begin
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                for (int j = 0; j < d; j++) m_wave.push_back(v);
            end
        end
        if (m_wave.size() > 0) begin
            m_tx   = m_wave.pop_front();
            m_busy = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
        m_irq = ctrl_pre[1] & empty_pre & !busy_pre;

        off = {addr_i[9:2], 2'b00};
        rd  = '0;
        er  = 1'b0;
        if (req_i) begin
            case (off)
                10'h000: begin
                    if (we_i) begin
                        if (full_pre) er = 1'b1;
                        else if (be_i[0]) m_fifo.push_back(wdata_i[7:0]);
                    end
                end
                10'h004: begin
                    if (we_i) er = 1'b1;
                    else rd = {16'h0, n[7:0], 5'b0, busy_pre, empty_pre, full_pre};
                end
                10'h008: begin
                    if (we_i) begin
                        if (be_i[0]) m_clkdiv[7:0]  = wdata_i[7:0];
                        if (be_i[1]) m_clkdiv[15:8] = wdata_i[15:8];
                    end else begin
                        rd = {16'h0, div_pre};
                    end
                end
                10'h00C: begin
                    if (we_i) begin
                        if (be_i[0]) m_ctrl = wdata_i[1:0];
                    end else begin
                        rd = {30'h0, ctrl_pre};
                    end
                end
                default: er = 1'b1;
            endcase
        end
        m_rvalid = req_i;
        m_rdata  = rd;
        m_err    = req_i & er;
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
    end

    initial forever begin
        @(negedge clk_i);
        if (m_live) begin
            check("tx_o", {31'b0, tx_o}, {31'b0, m_tx});
            check("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
            check("rvalid_o", {31'b0, rvalid_o}, {31'b0, m_rvalid});
            if (m_rvalid) begin
                check("rdata_o", rdata_o, m_rdata);
                check("err_o", {31'b0, err_o}, {31'b0, m_err});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic bus(input bit we, input logic [3:0] be, input logic [31:0] off,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = 32'h0004_0000 + off;
        wdata_i = wd;
        @(posedge clk_i);
        #1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        wdata_i = '0;
        rd      = rdata_o;
        er      = err_o;
        $display("bus we=%0d off=0x%02h wdata=0x%08h -> rdata=0x%08h err=%0d", we, off, wd, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;
    int          mism;
    int          falls;
    logic        prev;
    logic [9:0]  pat55     = 10'b1010101010;
    logic [19:0] pat_a5_3c = 20'b1001111000_1101001010;

    initial begin
        rst_i   = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = '0;
        wdata_i = '0;
        tick(2);
        rst_i = 1'b0;

        // Reset values
        bus(1'b0, 4'hF, 32'h4, 32'h0, rd, er);
        check("status_after_reset", rd, 32'h0000_0002);
        bus(1'b0, 4'hF, 32'h8, 32'h0, rd, er);
        check("clkdiv_after_reset", rd, 32'd868);
        check("irq_after_reset", {31'b0, irq_o}, 32'd0);

        // Single byte 0x55 at 4 clocks per bit
        bus(1'b1, 4'h3, 32'h8, 32'd4, rd, er);
        bus(1'b1, 4'h1, 32'hC, 32'h1, rd, er);
        bus(1'b1, 4'h1, 32'h0, 32'h55, rd, er);
        tick(1);
        mism = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_o !== pat55[i/4]) mism++;
            tick(1);
        end
        check("frame_0x55_bits", mism, 0);
        check("tx_idle_after_frame", {31'b0, tx_o}, 32'd1);
        bus(1'b0, 4'hF, 32'h4, 32'h0, rd, er);
        check("status_not_busy_after_frame", rd, 32'h0000_0002);

        // Back-to-back frames 0xA5, 0x3C at 2 clocks per bit
        bus(1'b1, 4'h3, 32'h8, 32'd2, rd, er);
        bus(1'b1, 4'h1, 32'h0, 32'hA5, rd, er);
        bus(1'b1, 4'h1, 32'h0, 32'h3C, rd, er);
        mism = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_o !== pat_a5_3c[i/2]) mism++;
            tick(1);
        end
        check("frames_a5_3c_no_gap", mism, 0);
        tick(2);

        // FIFO full with transmitter disabled
        bus(1'b1, 4'h1, 32'hC, 32'h0, rd, er);
        bus(1'b1, 4'h3, 32'h8, 32'd1, rd, er);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus(1'b1, 4'h1, 32'h0, 32'h00, rd, er);
            if (er !== 1'b0) mism++;
        end
        check("fill_push_errors", mism, 0);
        bus(1'b1, 4'h1, 32'h0, 32'h00, rd, er);
        check("push_when_full_err", {31'b0, er}, 32'd1);
        bus(1'b0, 4'hF, 32'h4, 32'h0, rd, er);
        check("status_full_count16", rd, 32'h0000_1001);
        bus(1'b1, 4'h1, 32'hC, 32'h1, rd, er);
        falls = 0;
        prev  = tx_o;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (prev === 1'b1 && tx_o === 1'b0) falls++;
            prev = tx_o;
        end
        check("frames_after_full", falls, DEPTH);

        // Interrupt
        bus(1'b1, 4'h1, 32'hC, 32'h3, rd, er);
        bus(1'b1, 4'h1, 32'h0, 32'h81, rd, er);
        mism = 0;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            if (irq_o !== 1'b0) mism++;
        end
        check("irq_low_during_frame", mism, 0);
        tick(1);
        check("irq_high_after_stop", {31'b0, irq_o}, 32'd1);
        bus(1'b1, 4'h1, 32'hC, 32'h1, rd, er);
        tick(1);
        check("irq_low_after_irq_en_clear", {31'b0, irq_o}, 32'd0);

        // Bus errors
        bus(1'b0, 4'hF, 32'h10, 32'h0, rd, er);
        check("unmapped_rvalid", {31'b0, rvalid_o}, 32'd1);
        check("unmapped_err", {31'b0, er}, 32'd1);
        bus(1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF, rd, er);
        check("status_write_err", {31'b0, er}, 32'd1);
        bus(1'b0, 4'hF, 32'h4, 32'h0, rd, er);
        check("status_unchanged", rd, 32'h0000_0002);

        // Reset in the middle of a frame with a read in flight
        bus(1'b1, 4'h3, 32'h8, 32'd4, rd, er);
        bus(1'b1, 4'h1, 32'h0, 32'hF0, rd, er);
        bus(1'b1, 4'h1, 32'h0, 32'h0F, rd, er);
        tick(10);
        rst_i  = 1'b1;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h0004_000C;
        tick(1);
        req_i = 1'b0;
        check("rvalid_suppressed_by_reset", {31'b0, rvalid_o}, 32'd0);
        check("tx_high_in_reset", {31'b0, tx_o}, 32'd1);
        tick(1);
        rst_i = 1'b0;
        bus(1'b0, 4'hF, 32'h4, 32'h0, rd, er);
        check("status_after_midframe_reset", rd, 32'h0000_0002);
        bus(1'b0, 4'hF, 32'h8, 32'h0, rd, er);
        check("clkdiv_after_midframe_reset", rd, 32'd868);
        check("irq_after_midframe_reset", {31'b0, irq_o}, 32'd0);

        // Partial CLKDIV write
        bus(1'b1, 4'h1, 32'h8, 32'h0000_1234, rd, er);
        bus(1'b0, 4'hF, 32'h8, 32'h0, rd, er);
        check("clkdiv_byte0_write", rd, 32'h0000_0334);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
